attitude_sample_sequencer: RTL and testbench

ATTITUDE_SAMPLE_SEQUENCER -- requirements
Module: attitude_sample_sequencer

---
 rtl/attitude_sample_sequencer_pkg.sv | 25 ++
 rtl/attitude_sample_sequencer_encoder.sv | 13 +
 rtl/attitude_sample_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_attitude_sample_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/attitude_sample_sequencer_pkg.sv
// Shared definitions for the attitude sample sequencer: FSM encodings,
// default sensor register map and the level-band used by the encoder.
package attitude_sample_sequencer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQ_ROLL  = 3'd1;
  localparam logic [2:0] ST_REQ_PITCH = 3'd2;
  localparam logic [2:0] ST_ENCODE    = 3'd3;
  localparam logic [2:0] ST_COMMIT    = 3'd4;

  localparam logic [7:0] DEF_ROLL_ADDR  = 8'h1C;
  localparam logic [7:0] DEF_PITCH_ADDR = 8'h1E;

  // Angles strictly inside +/-16 degrees (256 LSB at 16 LSB/degree) count as level.
  localparam logic signed [15:0] LEVEL_HI = 16'sd256;
  localparam logic signed [15:0] LEVEL_LO = -16'sd256;

  // {sign roll, sign pitch, roll level, pitch level}
  typedef logic [3:0] attitude_t;

  function automatic logic is_level(input logic [15:0] raw);
    is_level = ($signed(raw) > LEVEL_LO) && ($signed(raw) < LEVEL_HI);
  endfunction

endpackage

// File: rtl/attitude_sample_sequencer_encoder.sv
// Roll/pitch to 4-bit attitude code; purely combinational, zero latency,
// no flow control.
module Roll_Pitch_Encoder
  import attitude_sample_sequencer_pkg::*;
(
  input  logic [15:0] roll,
  input  logic [15:0] pitch,
  output attitude_t   code
);

  assign code = {roll[15], pitch[15], is_level(roll), is_level(pitch)};

endmodule

// File: rtl/attitude_sample_sequencer.sv
// Periodic roll/pitch sampler with debounced attitude commit. A sample takes
// two reads plus two cycles; the read engine throttles via i_Rd_Valid, bounded by a timeout.
module attitude_sample_sequencer
  import attitude_sample_sequencer_pkg::*;
#(
  parameter int         SAMPLE_PERIOD  = 500000,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         DEBOUNCE_N     = 3,
  parameter logic [7:0] ROLL_ADDR      = DEF_ROLL_ADDR,
  parameter logic [7:0] PITCH_ADDR     = DEF_PITCH_ADDR
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Enable,
  input  logic        i_Clr_Status,
  output logic        o_Rd_Req,
  output logic [7:0]  o_Rd_Addr,
  input  logic        i_Rd_Valid,
  input  logic [15:0] i_Rd_Data,
  output logic [15:0] o_Roll_Raw,
  output logic [15:0] o_Pitch_Raw,
  output logic [3:0]  o_Attitude,
  output logic        o_Update,
  output logic        o_Overrun,
  output logic [7:0]  o_Err_Count
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(DEBOUNCE_N + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(DEBOUNCE_N);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  logic [2:0]    state;
  logic          rd_req;
  logic [WW-1:0] wait_cnt;
  logic [15:0]   roll_hold;
  logic [15:0]   roll_raw;
  logic [15:0]   pitch_raw;

  attitude_t     enc_code;
  attitude_t     sample;
  attitude_t     candidate;
  attitude_t     next_cand;
  attitude_t     attitude;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] next_cnt;
  logic          update;

  logic          overrun;
  logic [7:0]    err_cnt;

  logic          in_req;
  logic          rd_accept;
  logic          timeout_evt;
  logic          overrun_evt;

  // Free-running sample timebase, independent of i_Enable.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign in_req      = (state == ST_REQ_ROLL) || (state == ST_REQ_PITCH);
  assign rd_accept   = in_req && rd_req && i_Rd_Valid;
  assign timeout_evt = in_req && rd_req && !i_Rd_Valid && (wait_cnt == WAIT_LAST);
  assign overrun_evt = tick && (state != ST_IDLE);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state    <= ST_IDLE;
      rd_req   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && i_Enable) begin
            state    <= ST_REQ_ROLL;
            rd_req   <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ST_REQ_ROLL, ST_REQ_PITCH: begin
          // Pitch enters with the request low for one cycle after the roll handshake.
          if (!rd_req) begin
            rd_req <= 1'b1;
          end else if (rd_accept) begin
            rd_req   <= 1'b0;
            wait_cnt <= '0;
            state    <= (state == ST_REQ_ROLL) ? ST_REQ_PITCH : ST_ENCODE;
          end else if (timeout_evt) begin
            rd_req   <= 1'b0;
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_ENCODE: state <= ST_COMMIT;
        ST_COMMIT: state <= ST_IDLE;
        default: begin
          state  <= ST_IDLE;
          rd_req <= 1'b0;
        end
      endcase
    end
  end

  // Roll is held privately so both raw outputs change together.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      roll_hold <= '0;
      roll_raw  <= '0;
      pitch_raw <= '0;
    end else if (rd_accept) begin
      if (state == ST_REQ_ROLL) begin
        roll_hold <= i_Rd_Data;
      end else begin
        roll_raw  <= roll_hold;
        pitch_raw <= i_Rd_Data;
      end
    end
  end

  Roll_Pitch_Encoder u_encoder (
    .roll  (roll_raw),
    .pitch (pitch_raw),
    .code  (enc_code)
  );

  always_comb begin
    next_cand = candidate;
    next_cnt  = db_cnt;
    if (sample == candidate) begin
      if (db_cnt < CNT_SAT) begin
        next_cnt = db_cnt + CW'(1);
      end
    end else begin
      next_cand = sample;
      next_cnt  = CW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sample    <= '0;
      candidate <= '0;
      db_cnt    <= '0;
      attitude  <= '0;
      update    <= 1'b0;
    end else begin
      update <= 1'b0;
      if (state == ST_ENCODE) begin
        sample <= enc_code;
      end else if (state == ST_COMMIT) begin
        candidate <= next_cand;
        db_cnt    <= next_cnt;
        if ((next_cnt >= CNT_SAT) && (next_cand != attitude)) begin
          attitude <= next_cand;
          update   <= 1'b1;
        end
      end
    end
  end

  // Set/increment wins over a coincident clear.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      overrun <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (overrun_evt) begin
        overrun <= 1'b1;
      end else if (i_Clr_Status) begin
        overrun <= 1'b0;
      end

      if (timeout_evt) begin
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else if (i_Clr_Status) begin
        err_cnt <= '0;
      end
    end
  end

  assign o_Rd_Req    = rd_req;
  assign o_Rd_Addr   = rd_req ? ((state == ST_REQ_PITCH) ? PITCH_ADDR : ROLL_ADDR) : 8'h00;
  assign o_Roll_Raw  = roll_raw;
  assign o_Pitch_Raw = pitch_raw;
  assign o_Attitude  = attitude;
  assign o_Update    = update;
  assign o_Overrun   = overrun;
  assign o_Err_Count = err_cnt;

endmodule

// File: tb/tb_attitude_sample_sequencer.sv
// Directed bench for attitude_sample_sequencer with a behavioural read engine
// answering o_Rd_Req after a programmable latency.
module tb_attitude_sample_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_Enable;
  logic        i_Clr_Status;
  logic        o_Rd_Req;
  logic [7:0]  o_Rd_Addr;
  logic        i_Rd_Valid;
  logic [15:0] i_Rd_Data;
  logic [15:0] o_Roll_Raw;
  logic [15:0] o_Pitch_Raw;
  logic [3:0]  o_Attitude;
  logic        o_Update;
  logic        o_Overrun;
  logic [7:0]  o_Err_Count;

  int checks   = 0;
  int failures = 0;

  int          resp_lat  = 1;
  bit          pitch_on  = 1'b1;
  logic [15:0] roll_val  = 16'h0000;
  logic [15:0] pitch_val = 16'h0000;
  int          req_age   = 0;
  int          pitch_cnt = 0;
  int          upd_cnt   = 0;

  attitude_sample_sequencer #(
    .SAMPLE_PERIOD  (16),
    .TIMEOUT_CYCLES (4096),
    .DEBOUNCE_N     (3),
    .ROLL_ADDR      (8'h1C),
    .PITCH_ADDR     (8'h1E)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_Enable     (i_Enable),
    .i_Clr_Status (i_Clr_Status),
    .o_Rd_Req     (o_Rd_Req),
    .o_Rd_Addr    (o_Rd_Addr),
    .i_Rd_Valid   (i_Rd_Valid),
    .i_Rd_Data    (i_Rd_Data),
    .o_Roll_Raw   (o_Roll_Raw),
    .o_Pitch_Raw  (o_Pitch_Raw),
    .o_Attitude   (o_Attitude),
    .o_Update     (o_Update),
    .o_Overrun    (o_Overrun),
    .o_Err_Count  (o_Err_Count)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read engine: answers resp_lat cycles after the request is seen; pitch can be withheld.
  initial begin
    i_Rd_Valid = 1'b0;
    i_Rd_Data  = 16'h0000;
    forever begin
      @(posedge i_Clk);
      #1;
      i_Rd_Valid = 1'b0;
      if (o_Rd_Req) begin
        if (req_age >= resp_lat && (o_Rd_Addr == 8'h1C || pitch_on)) begin
          i_Rd_Valid = 1'b1;
          i_Rd_Data  = (o_Rd_Addr == 8'h1C) ? roll_val : pitch_val;
          if (o_Rd_Addr == 8'h1E) pitch_cnt++;
          req_age = 0;
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_Clk);
      #1;
      if (o_Update) upd_cnt++;
    end
  end

  // Returns on a negedge once n more pitch reads are answered and the commit has settled.
  task automatic wait_samples(input int n, input int budget);
    int target;
    int k;
    target = pitch_cnt + n;
    k = 0;
    while (pitch_cnt < target && k < budget) begin
      @(negedge i_Clk);
      k++;
    end
    if (pitch_cnt < target) chk("sample_wait", pitch_cnt, target);
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  task automatic wait_req(input logic [7:0] addr, input int budget);
    int k;
    k = 0;
    while (!(o_Rd_Req && o_Rd_Addr == addr) && k < budget) begin
      @(negedge i_Clk);
      k++;
    end
    if (!(o_Rd_Req && o_Rd_Addr == addr)) chk("req_wait", {24'h0, o_Rd_Addr}, {24'h0, addr});
  endtask

  initial begin
    int hi;
    int rq;
    logic prev_req;

    i_Rst_n      = 1'b0;
    i_Enable     = 1'b0;
    i_Clr_Status = 1'b0;
    repeat (3) @(negedge i_Clk);
    chk("rst_rd_req",   o_Rd_Req,    0);
    chk("rst_rd_addr",  o_Rd_Addr,   0);
    chk("rst_attitude", o_Attitude,  0);
    chk("rst_roll",     o_Roll_Raw,  0);
    chk("rst_pitch",    o_Pitch_Raw, 0);
    chk("rst_overrun",  o_Overrun,   0);
    chk("rst_err",      o_Err_Count, 0);
    chk("rst_update",   o_Update,    0);
    i_Rst_n = 1'b1;

    // Alternating 1001 / 0011 never settles.
    i_Enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      roll_val  = (i % 2 == 0) ? 16'hFF00 : 16'h0010;
      pitch_val = (i % 2 == 0) ? 16'h00A0 : 16'h0020;
      wait_samples(1, 100);
      chk("alt_roll_raw",  o_Roll_Raw,  roll_val);
      chk("alt_pitch_raw", o_Pitch_Raw, pitch_val);
    end
    chk("alt_attitude", o_Attitude, 4'b0000);
    chk("alt_updates",  upd_cnt,    0);

    // Three equal samples commit 1001 with a single update.
    roll_val  = 16'hFF00;
    pitch_val = 16'h00A0;
    wait_samples(2, 100);
    chk("deb2_attitude", o_Attitude, 4'b0000);
    wait_samples(1, 100);
    chk("deb3_attitude", o_Attitude, 4'b1001);
    chk("deb3_updates",  upd_cnt,    1);
    wait_samples(1, 100);
    chk("deb4_updates",  upd_cnt,    1);

    // Roll exactly zero, pitch -32 degrees -> 0110.
    roll_val  = 16'h0000;
    pitch_val = 16'hFE00;
    wait_samples(3, 200);
    chk("neg_pitch_attitude", o_Attitude, 4'b0110);
    chk("neg_pitch_updates",  upd_cnt,    2);

    // Just inside the level band on both axes -> 0111.
    roll_val  = 16'h00FF;
    pitch_val = 16'hFF01;
    wait_samples(3, 200);
    chk("band_attitude", o_Attitude, 4'b0111);
    chk("band_updates",  upd_cnt,    3);

    // Pitch read withheld: request held for the full timeout, then abandoned.
    roll_val  = 16'h1234;
    pitch_val = 16'h4321;
    pitch_on  = 1'b0;
    wait_req(8'h1E, 100);
    hi = 0;
    while (o_Rd_Req && hi < 6000) begin
      @(negedge i_Clk);
      hi++;
    end
    pitch_on = 1'b1;
    chk("timeout_req_cycles", hi,          4096);
    chk("timeout_err",        o_Err_Count, 1);
    chk("timeout_pitch_raw",  o_Pitch_Raw, 16'hFF01);
    chk("timeout_roll_raw",   o_Roll_Raw,  16'h00FF);
    chk("timeout_attitude",   o_Attitude,  4'b0111);
    chk("timeout_overrun",    o_Overrun,   1);

    wait_samples(1, 100);
    chk("post_timeout_roll", o_Roll_Raw, 16'h1234);
    i_Clr_Status = 1'b1;
    @(negedge i_Clk);
    i_Clr_Status = 1'b0;
    chk("clr1_overrun", o_Overrun,   0);
    chk("clr1_err",     o_Err_Count, 0);

    // Reads slower than the sample period cause overrun.
    resp_lat = 20;
    wait_samples(1, 200);
    chk("slow_overrun",   o_Overrun,   1);
    chk("slow_pitch_raw", o_Pitch_Raw, 16'h4321);
    resp_lat = 1;
    wait_samples(2, 200);
    chk("slow_attitude", o_Attitude, 4'b0000);
    chk("slow_updates",  upd_cnt,    4);
    i_Clr_Status = 1'b1;
    @(negedge i_Clk);
    i_Clr_Status = 1'b0;
    chk("clr2_overrun", o_Overrun,   0);
    chk("clr2_err",     o_Err_Count, 0);

    // Enable dropped during the roll read: sequence completes, then nothing more.
    roll_val  = 16'h0300;
    pitch_val = 16'h0000;
    wait_req(8'h1C, 40);
    i_Enable = 1'b0;
    wait_samples(1, 100);
    chk("dis_roll_raw",  o_Roll_Raw,  16'h0300);
    chk("dis_pitch_raw", o_Pitch_Raw, 16'h0000);
    rq = 0;
    prev_req = o_Rd_Req;
    for (int i = 0; i < 80; i++) begin
      @(negedge i_Clk);
      if (o_Rd_Req && !prev_req) rq++;
      prev_req = o_Rd_Req;
    end
    chk("dis_no_requests", rq, 0);

    // Reset while the pitch read is outstanding.
    i_Enable = 1'b1;
    resp_lat = 20;
    roll_val  = 16'h0500;
    pitch_val = 16'h0600;
    wait_req(8'h1E, 200);
    #2;
    i_Rst_n = 1'b0;
    #1;
    chk("arst_rd_req",   o_Rd_Req,    0);
    chk("arst_rd_addr",  o_Rd_Addr,   0);
    chk("arst_roll",     o_Roll_Raw,  0);
    chk("arst_pitch",    o_Pitch_Raw, 0);
    chk("arst_attitude", o_Attitude,  0);
    chk("arst_overrun",  o_Overrun,   0);
    chk("arst_err",      o_Err_Count, 0);
    chk("arst_update",   o_Update,    0);
    @(negedge i_Clk);
    i_Rst_n  = 1'b1;
    resp_lat = 1;
    hi = 0;
    while (!o_Rd_Req && hi < 40) begin
      @(negedge i_Clk);
      hi++;
    end
    chk("arst_restart_req",  o_Rd_Req,  1);
    chk("arst_restart_addr", o_Rd_Addr, 8'h1C);
    wait_samples(1, 100);
    chk("arst_restart_roll", o_Roll_Raw, 16'h0500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
